// File: rtl/uart_tx_if.sv
// Byte handshake and serial-line bundle between the core and the UART transmitter.
// The master side queues bytes; the slave side (uart_tx) reports status and drives tx.
interface uart_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_ready,
        input  tx_busy,
        input  tx_done,
        input  tx
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_ready,
        output tx_busy,
        output tx_done,
        output tx
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register so that queued bytes
// follow the current frame without an idle gap. The serial line is registered.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       reset,
    uart_tx_if.slave   bus
);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    localparam logic [15:0] BaudMax = 16'(CLKS_PER_BIT - 1);

    state_e      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        tx_q, tx_d;

    logic bit_end;
    logic accept;
    logic load_direct;

    assign bit_end = (state_q != StIdle) && (baud_q == BaudMax);
    assign accept  = bus.tx_start && !hold_full_q;

    // A byte skips the holding register when the line is free now or frees on this edge.
    assign load_direct = accept && ((state_q == StIdle) || ((state_q == StStop) && bit_end));

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        if (state_q == StIdle || bit_end) begin
            baud_d = 16'd0;
        end else begin
            baud_d = baud_q + 16'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d = bus.tx_data;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = 3'd0;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = StStart;
                    end else if (accept) begin
                        shift_d = bus.tx_data;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept && !load_direct) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end
    end

    // Line level follows the next state so tx changes the cycle after the causing edge.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StIdle:  tx_d = 1'b1;
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            StStop:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            baud_q      <= 16'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.tx_ready = !hold_full_q;
    assign bus.tx_busy  = (state_q != StIdle);
    assign bus.tx_done  = (state_q == StStop) && bit_end;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit. Cycle c is sampled at the negedge
// before posedge c, and inputs for cycle c are applied at that same negedge.
module tb_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    uart_tx_if bus ();

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Expected line level in cycle c for a frame of byte b accepted in cycle a.
    function automatic logic exp_tx(input int c, input int a, input logic [7:0] b);
        int k;
        if (c <= a || c > a + 10 * CPB) return 1'b1;
        k = (c - a - 1) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    // True when cycle c is the mid-bit sample point of a data bit of a frame accepted at a.
    function automatic bit mid_data(input int c, input int a);
        int d;
        d = c - a;
        return (d >= CPB + 2) && (d <= 8 * CPB + 2) && (((d - 2) % CPB) == 0);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_data = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.tx, bus.tx_ready, bus.tx_busy, bus.tx_done} !== 4'b1100) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got tx/ready/busy/done=%b required=1100", c,
                         {bus.tx, bus.tx_ready, bus.tx_busy, bus.tx_done});
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] rx;
        logic       e;
        rx = 8'h00;
        for (int c = 0; c <= 48; c++) begin
            @(negedge clk);
            e = exp_tx(c, 0, 8'hA5);
            checks++;
            if (bus.tx !== e) begin
                failures++;
                $display("FAIL single_tx cycle=%0d got=%b required=%b", c, bus.tx, e);
            end
            checks++;
            if (bus.tx_done !== (c == 40)) begin
                failures++;
                $display("FAIL single_done cycle=%0d got=%b required=%b", c, bus.tx_done, c == 40);
            end
            checks++;
            if (bus.tx_busy !== (c >= 1 && c <= 40)) begin
                failures++;
                $display("FAIL single_busy cycle=%0d got=%b required=%b", c, bus.tx_busy,
                         c >= 1 && c <= 40);
            end
            if (mid_data(c, 0)) rx = {bus.tx, rx[7:1]};
            bus.tx_start = (c == 0);
            bus.tx_data  = (c == 0) ? 8'hA5 : 8'h00;
        end
        checks++;
        if (rx !== 8'hA5) begin
            failures++;
            $display("FAIL single_decode got=%h required=a5", rx);
        end
    endtask

    task automatic test_back_to_back(input bit third);
        logic [7:0] rx0, rx1;
        logic       e;
        rx0 = 8'h00;
        rx1 = 8'h00;
        for (int c = 0; c <= 88; c++) begin
            @(negedge clk);
            e = (c <= 40) ? exp_tx(c, 0, 8'h55) : exp_tx(c, 40, 8'h0F);
            checks++;
            if (bus.tx !== e) begin
                failures++;
                $display("FAIL b2b_tx third=%0d cycle=%0d got=%b required=%b", third, c, bus.tx, e);
            end
            checks++;
            if (bus.tx_ready !== !(c >= 11 && c <= 40)) begin
                failures++;
                $display("FAIL b2b_ready third=%0d cycle=%0d got=%b required=%b", third, c,
                         bus.tx_ready, !(c >= 11 && c <= 40));
            end
            checks++;
            if (bus.tx_done !== (c == 40 || c == 80)) begin
                failures++;
                $display("FAIL b2b_done third=%0d cycle=%0d got=%b required=%b", third, c,
                         bus.tx_done, c == 40 || c == 80);
            end
            checks++;
            if (bus.tx_busy !== (c >= 1 && c <= 80)) begin
                failures++;
                $display("FAIL b2b_busy third=%0d cycle=%0d got=%b required=%b", third, c,
                         bus.tx_busy, c >= 1 && c <= 80);
            end
            if (mid_data(c, 0)) rx0 = {bus.tx, rx0[7:1]};
            if (mid_data(c, 40)) rx1 = {bus.tx, rx1[7:1]};
            bus.tx_start = (c == 0) || (c == 10) || (third && c == 20);
            bus.tx_data  = (c == 0) ? 8'h55 : (c == 10) ? 8'h0F : (c == 20) ? 8'hFF : 8'hEE;
        end
        checks++;
        if ({rx0, rx1} !== 16'h550F) begin
            failures++;
            $display("FAIL b2b_decode third=%0d got=%h required=550f", third, {rx0, rx1});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic e;
        for (int c = 0; c <= 66; c++) begin
            @(negedge clk);
            e = (c <= 15) ? exp_tx(c, 0, 8'h00) : exp_tx(c, 20, 8'h81);
            checks++;
            if (bus.tx !== e) begin
                failures++;
                $display("FAIL rst_mid_tx cycle=%0d got=%b required=%b", c, bus.tx, e);
            end
            checks++;
            if (bus.tx_busy !== ((c >= 1 && c <= 15) || (c >= 21 && c <= 60))) begin
                failures++;
                $display("FAIL rst_mid_busy cycle=%0d got=%b", c, bus.tx_busy);
            end
            checks++;
            if ({bus.tx_ready, bus.tx_done} !== {1'b1, c == 60}) begin
                failures++;
                $display("FAIL rst_mid_ready_done cycle=%0d got=%b required=%b", c,
                         {bus.tx_ready, bus.tx_done}, {1'b1, c == 60});
            end
            reset        = (c == 15);
            bus.tx_start = (c == 0) || (c == 20);
            bus.tx_data  = (c == 0) ? 8'h00 : (c == 20) ? 8'h81 : 8'h5A;
        end
    endtask

    task automatic test_data_stability();
        logic [7:0] rx;
        logic       e;
        rx = 8'h00;
        for (int c = 0; c <= 46; c++) begin
            @(negedge clk);
            e = exp_tx(c, 0, 8'h3C);
            checks++;
            if (bus.tx !== e) begin
                failures++;
                $display("FAIL stable_tx cycle=%0d got=%b required=%b", c, bus.tx, e);
            end
            if (mid_data(c, 0)) rx = {bus.tx, rx[7:1]};
            bus.tx_start = (c == 0);
            bus.tx_data  = (c == 0) ? 8'h3C : 8'hC3;
        end
        checks++;
        if (rx !== 8'h3C) begin
            failures++;
            $display("FAIL stable_decode got=%h required=3c", rx);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        test_reset();
        test_single();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_reset_mid_frame();
        test_data_stability();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial 8N1 UART transmitter: the transmit direction of the board UART link.
- The CPU's UART result byte (`uart_result_data`, produced by the register-file/ID path) is handed in with a start pulse and shifted out LSB first on `tx`.
- A one-entry holding register lets the core queue the next byte while the current frame is on the wire, so back-to-back frames have no idle gap.
- Sits beside the UART receiver in the top level; drives the board TX pin.

Parameters:
- `CLKS_PER_BIT`, 10417, clock cycles per serial bit (100 MHz / 9600 baud); legal range 2..65535.

Ports:
- `clk`  input  1  system clock
- `reset`  input  1  synchronous reset, active-high
- `tx_start`  input  1  request to send `tx_data`; sampled every cycle
- `tx_data`  input  8  byte to send; sampled only in an accept cycle
- `tx_ready`  output  1  1 = a `tx_start` this cycle will be accepted (holding register empty)
- `tx_busy`  output  1  1 = a frame is in progress (state != IDLE)
- `tx_done`  output  1  one-cycle pulse on the cycle the stop bit of each frame completes
- `tx`  output  1  serial line; idle high; registered output

Behaviour:
- Clock and reset: single clock `clk`; reset is synchronous and active-high.
- Reset values (at the first `clk` edge with `reset`=1): `tx`=1, `tx_busy`=0, `tx_done`=0, `tx_ready`=1, state=IDLE, baud counter=0, bit index=0, holding register empty. Reset overrides everything, including mid-frame; no partial frame resumes.
- Frame format: start bit 0, data[0]..data[7], stop bit 1. Each bit is held exactly `CLKS_PER_BIT` cycles, so one frame = 10*`CLKS_PER_BIT` cycles.
- Accept: the edge where `tx_start`=1 and `tx_ready`=1.
  - If state=IDLE, or the stop bit ends on this same edge: `tx_data` loads straight into the shift register, state goes to START, baud counter=0.
  - Otherwise: `tx_data` loads into the holding register and `tx_ready` drops to 0.
- `tx_start` while `tx_ready`=0 is ignored; the byte is dropped, with no error flag.
- Baud counter: counts 0..`CLKS_PER_BIT`-1. Reaching `CLKS_PER_BIT`-1 ends the current bit; the counter returns to 0.
- State machine:
  - IDLE: `tx`=1. On accept → START.
  - START: `tx`=0. At bit end → DATA, bit index=0.
  - DATA: `tx`=shift[0]. At bit end, shift right.
    - If bit index=7 → STOP.
    - Otherwise bit index+1.
  - STOP: `tx`=1. At bit end, pulse `tx_done`=1 for that one cycle, then:
    - holding register full → move it to the shift register, clear the holding register, `tx_ready`=1, → START (no idle cycle);
    - else accept on this edge → START with the new byte;
    - else → IDLE.
- Latency: `tx` changes on the cycle after the edge that causes the transition. The accept edge in IDLE puts `tx`=0 from the next cycle.
- `tx_busy`: 1 in START, DATA and STOP.
- Data stability: `tx_data` may change at any time after its accept cycle without affecting the frame.
- Width rule: the baud counter is 16 bits.

Test Plan:
- Reset, no stimulus: `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0 for 100 cycles.
- `CLKS_PER_BIT`=4, accept 0xA5 in IDLE at cycle 0 → `tx` over cycles 1..40 = 0 ×4, then 1,0,1,0,0,1,0,1 (×4 each), then 1 ×4. `tx_done` high at cycle 40 only. `tx_busy`=0 from cycle 41.
- `CLKS_PER_BIT`=4, accept 0x55 at cycle 0, then accept 0x0F at cycle 10 → `tx_ready`=0 cycles 11..40. The second start bit begins at cycle 41 with no high gap. Both bytes decode correctly; `tx_done` pulses at cycles 40 and 80.
- As the previous scenario, plus a third `tx_start` with 0xFF at cycle 20 → ignored: only 0x55 and 0x0F appear; line idle from cycle 81.
- `CLKS_PER_BIT`=4, accept 0x00, assert `reset` at cycle 15 → `tx`=1, `tx_busy`=0, `tx_ready`=1 from cycle 16. The next accept sends a clean full frame.
- Accept 0x3C, then change `tx_data` to 0xC3 one cycle later → 0x3C is transmitted.
